// File: rtl/load_sequencer_if.sv
// -----------------------------------------------------------------------------
// load_sequencer_if
// Reload-value request channel between a producer and load_sequencer.
//   req_valid : producer offers req_data this cycle
//   req_data  : reload value (WIDTH bits)
//   req_ready : consumer can accept a value this cycle
// A value transfers on a rising edge where req_valid and req_ready are both 1.
// Modports: master = producer side, slave = consumer (load_sequencer) side.
// -----------------------------------------------------------------------------
interface load_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             req_valid;
    logic [WIDTH-1:0] req_data;
    logic             req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );
endinterface : load_sequencer_if

// File: rtl/load_sequencer.sv
// -----------------------------------------------------------------------------
// load_sequencer
// Upstream feeder for a WIDTH-bit loadable up-counter. Reload values arrive
// over the req channel and are buffered in a DEPTH-entry FIFO. When the
// counter reaches its pre-terminal value (TERM_VAL-1), or force_i is raised,
// the FIFO head is issued as a one-cycle load pulse so that the counter takes
// the new value instead of wrapping. A wrap (or force) with an empty FIFO is
// flagged as a sticky underrun.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high reset
//   req            slave modport of load_sequencer_if (valid/data/ready)
//   force_i        in   load FIFO head at next edge regardless of count
//   count_i        in   counter's current registered value
//   clr_i          in   clears the sticky underrun flag (and counter)
//   load_o         out  registered one-cycle load pulse
//   load_val_o     out  registered load value, holds between loads
//   fifo_level_o   out  number of stored entries
//   underrun_o     out  sticky underrun flag
//   underrun_cnt_o out  8-bit saturating underrun counter
//                       (only with LOAD_SEQUENCER_UNDERRUN_CNT_EN defined)
//
// Optional feature macro: LOAD_SEQUENCER_UNDERRUN_CNT_EN
// -----------------------------------------------------------------------------
module load_sequencer #(
    parameter int               WIDTH    = 4,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] TERM_VAL = {WIDTH{1'b1}}
) (
    input  logic                     clk,
    input  logic                     reset,
    load_sequencer_if.slave          req,
    input  logic                     force_i,
    input  logic [WIDTH-1:0]         count_i,
    input  logic                     clr_i,
    output logic                     load_o,
    output logic [WIDTH-1:0]         load_val_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     underrun_o
`ifdef LOAD_SEQUENCER_UNDERRUN_CNT_EN
    ,
    output logic [7:0]               underrun_cnt_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // Pre-terminal value; subtraction wraps modulo 2^WIDTH by construction.
    localparam logic [WIDTH-1:0] TRIG_VAL = TERM_VAL - WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_LOAD  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ready_q, ready_d;
    logic             load_q, load_d;
    logic [WIDTH-1:0] load_val_q, load_val_d;
    logic             underrun_q, underrun_d;
`ifdef LOAD_SEQUENCER_UNDERRUN_CNT_EN
    logic [7:0]       ur_cnt_q, ur_cnt_d;
`endif

    logic fire_s;
    logic push_s;
    logic pop_s;
    logic underrun_set_s;

    assign fire_s = (count_i == TRIG_VAL) || force_i;
    // ready_q is the registered not-full flag, so a full FIFO never accepts,
    // even when a pop happens in the same cycle.
    assign push_s = req.req_valid && ready_q;

    // Next-state, FIFO bookkeeping and output computation.
    always_comb begin
        state_d        = state_q;
        pop_s          = 1'b0;
        load_d         = 1'b0;
        load_val_d     = load_val_q;
        underrun_set_s = 1'b0;

        // Load decision: only ARMED pops; IDLE flags underrun; LOAD/HOLD ignore.
        case (state_q)
            ST_IDLE: begin
                if (fire_s) begin
                    underrun_set_s = 1'b1;
                end else begin
                    underrun_set_s = 1'b0;
                end
            end
            ST_ARMED: begin
                if (fire_s) begin
                    pop_s      = 1'b1;
                    load_d     = 1'b1;
                    load_val_d = mem_q[rd_ptr_q];
                end else begin
                    pop_s      = 1'b0;
                end
            end
            ST_LOAD: begin
                pop_s = 1'b0;
            end
            ST_HOLD: begin
                pop_s = 1'b0;
            end
            default: begin
                pop_s = 1'b0;
            end
        endcase

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        ready_d = (level_d != LW'(DEPTH));

        // State transitions use level_d so ARMED coincides with a visible entry.
        case (state_q)
            ST_IDLE: begin
                if (level_d != LW'(0)) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (pop_s) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_LOAD: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // Blackout cycle: a loaded TERM_VAL-1 shows up on count_i here.
                if (level_d != LW'(0)) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Set wins over clear.
        if (underrun_set_s) begin
            underrun_d = 1'b1;
        end else if (clr_i) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end

`ifdef LOAD_SEQUENCER_UNDERRUN_CNT_EN
        // Increment wins over clear; with both, the count restarts at 1.
        if (underrun_set_s && clr_i) begin
            ur_cnt_d = 8'd1;
        end else if (underrun_set_s) begin
            if (ur_cnt_q == 8'd255) begin
                ur_cnt_d = 8'd255;
            end else begin
                ur_cnt_d = ur_cnt_q + 8'd1;
            end
        end else if (clr_i) begin
            ur_cnt_d = 8'd0;
        end else begin
            ur_cnt_d = ur_cnt_q;
        end
`endif
    end

    // Control state, pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ready_q    <= 1'b1;
            load_q     <= 1'b0;
            load_val_q <= '0;
            underrun_q <= 1'b0;
`ifdef LOAD_SEQUENCER_UNDERRUN_CNT_EN
            ur_cnt_q   <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ready_q    <= ready_d;
            load_q     <= load_d;
            load_val_q <= load_val_d;
            underrun_q <= underrun_d;
`ifdef LOAD_SEQUENCER_UNDERRUN_CNT_EN
            ur_cnt_q   <= ur_cnt_d;
`endif
        end
    end

    // FIFO storage; no reset needed since pointers/level gate all reads.
    always_ff @(posedge clk) begin
        if (push_s && !reset) begin
            mem_q[wr_ptr_q] <= req.req_data;
        end
    end

    assign req.req_ready  = ready_q;
    assign load_o         = load_q;
    assign load_val_o     = load_val_q;
    assign fifo_level_o   = level_q;
    assign underrun_o     = underrun_q;
`ifdef LOAD_SEQUENCER_UNDERRUN_CNT_EN
    assign underrun_cnt_o = ur_cnt_q;
`endif

endmodule : load_sequencer

// File: tb/tb_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_load_sequencer
// Directed, self-checking bench for load_sequencer (WIDTH=4, DEPTH=4,
// TERM_VAL=4'hF). Accepted reload values go into a scoreboard queue and are
// popped/compared whenever a load pulse is expected.
// -----------------------------------------------------------------------------
module tb_load_sequencer;
    logic       clk;
    logic       reset;
    logic       force_i;
    logic [3:0] count_i;
    logic       clr_i;
    logic       load_o;
    logic [3:0] load_val_o;
    logic [2:0] fifo_level_o;
    logic       underrun_o;
`ifdef LOAD_SEQUENCER_UNDERRUN_CNT_EN
    logic [7:0] underrun_cnt_o;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] sb[$];

    load_sequencer_if #(.WIDTH(4)) req_if ();

    load_sequencer #(
        .WIDTH   (4),
        .DEPTH   (4),
        .TERM_VAL(4'hF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req_if.slave),
        .force_i       (force_i),
        .count_i       (count_i),
        .clr_i         (clr_i),
        .load_o        (load_o),
        .load_val_o    (load_val_o),
        .fifo_level_o  (fifo_level_o),
        .underrun_o    (underrun_o)
`ifdef LOAD_SEQUENCER_UNDERRUN_CNT_EN
        ,
        .underrun_cnt_o(underrun_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expect a load pulse now, carrying the oldest scoreboard entry.
    task automatic check_load(input string tag);
        logic [3:0] exp;
        check({tag, "_load"}, {31'd0, load_o}, 32'd1);
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_val: observed %0h expected <scoreboard empty>", tag, load_val_o);
        end else begin
            exp = sb.pop_front();
            check({tag, "_val"}, {28'd0, load_val_o}, {28'd0, exp});
        end
    endtask

    // Offer one value for one cycle; it must be accepted.
    task automatic push_val(input logic [3:0] v);
        check("push_ready", {31'd0, req_if.req_ready}, 32'd1);
        req_if.req_valid = 1'b1;
        req_if.req_data  = v;
        tick();
        req_if.req_valid = 1'b0;
        sb.push_back(v);
    endtask

    initial begin
        reset            = 1'b1;
        force_i          = 1'b0;
        count_i          = 4'h0;
        clr_i            = 1'b0;
        req_if.req_valid = 1'b0;
        req_if.req_data  = 4'h0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_load",     {31'd0, load_o},           32'd0);
        check("rst_val",      {28'd0, load_val_o},       32'd0);
        check("rst_level",    {29'd0, fifo_level_o},     32'd0);
        check("rst_underrun", {31'd0, underrun_o},       32'd0);
        check("rst_ready",    {31'd0, req_if.req_ready}, 32'd1);

        // Basic trigger-timed load
        push_val(4'h3);
        push_val(4'h9);
        check("basic_level2", {29'd0, fifo_level_o}, 32'd2);
        count_i = 4'hD;
        tick();
        check("basic_noload_d", {31'd0, load_o}, 32'd0);
        count_i = 4'hE;
        tick();
        check_load("basic");
        check("basic_level1", {29'd0, fifo_level_o}, 32'd1);
        count_i = 4'hF;
        tick();
        check("basic_hold_noload", {31'd0, load_o}, 32'd0);
        count_i = 4'h0;
        tick();

        // Fill to DEPTH; a 5th offer coincides with a pop and must be refused
        push_val(4'hA);
        push_val(4'hB);
        push_val(4'hC);
        check("full_level", {29'd0, fifo_level_o},     32'd4);
        check("full_ready", {31'd0, req_if.req_ready}, 32'd0);
        req_if.req_valid = 1'b1;
        req_if.req_data  = 4'h7;
        count_i          = 4'hE;
        tick();
        req_if.req_valid = 1'b0;
        check_load("full_pop");
        check("full_level_after", {29'd0, fifo_level_o},     32'd3);
        check("full_ready_after", {31'd0, req_if.req_ready}, 32'd1);
        count_i = 4'h0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            count_i = 4'hE;
            tick();
            check_load("drain");
            count_i = 4'h0;
            tick();
            tick();
        end
        check("drain_level", {29'd0, fifo_level_o}, 32'd0);

        // Underrun: empty FIFO at trigger
        count_i = 4'hE;
        tick();
        check("ur_noload", {31'd0, load_o},     32'd0);
        check("ur_set",    {31'd0, underrun_o}, 32'd1);
`ifdef LOAD_SEQUENCER_UNDERRUN_CNT_EN
        check("ur_cnt1", {24'd0, underrun_cnt_o}, 32'd1);
`endif
        count_i = 4'h0;
        tick();
        tick();
        check("ur_sticky", {31'd0, underrun_o}, 32'd1);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("ur_clr", {31'd0, underrun_o}, 32'd0);
        count_i = 4'hE;
        clr_i   = 1'b1;
        tick();
        clr_i = 1'b0;
        check("ur_set_wins", {31'd0, underrun_o}, 32'd1);
`ifdef LOAD_SEQUENCER_UNDERRUN_CNT_EN
        check("ur_cnt_set_wins", {24'd0, underrun_cnt_o}, 32'd1);
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        check("ur_cnt_sat", {24'd0, underrun_cnt_o}, 32'd255);
`endif
        count_i = 4'h0;
        clr_i   = 1'b1;
        tick();
        clr_i = 1'b0;
        check("ur_clr2", {31'd0, underrun_o}, 32'd0);
`ifdef LOAD_SEQUENCER_UNDERRUN_CNT_EN
        check("ur_cnt_clr", {24'd0, underrun_cnt_o}, 32'd0);
`endif

        // Loaded value equal to TERM_VAL-1 must not re-trigger during HOLD
        push_val(4'hE);
        push_val(4'h5);
        count_i = 4'hE;
        tick();
        check_load("hold_first");
        count_i = 4'hF;
        tick();
        count_i = 4'hE;
        tick();
        check("hold_no_second", {31'd0, load_o},       32'd0);
        check("hold_level",     {29'd0, fifo_level_o}, 32'd1);
        check("hold_no_ur",     {31'd0, underrun_o},   32'd0);
        count_i = 4'h0;
        tick();
        count_i = 4'hE;
        tick();
        check_load("hold_next");
        count_i = 4'h0;
        tick();
        tick();

        // Forced load off-trigger, then force together with trigger
        push_val(4'h6);
        count_i = 4'h2;
        force_i = 1'b1;
        tick();
        force_i = 1'b0;
        count_i = 4'h0;
        check_load("force");
        check("force_level0", {29'd0, fifo_level_o}, 32'd0);
        tick();
        tick();
        check("force_no_ur", {31'd0, underrun_o}, 32'd0);
        push_val(4'h8);
        push_val(4'h4);
        count_i = 4'hE;
        force_i = 1'b1;
        tick();
        force_i = 1'b0;
        count_i = 4'h0;
        check_load("force_trig");
        check("force_trig_level", {29'd0, fifo_level_o}, 32'd1);
        tick();
        check("force_trig_hold", {31'd0, load_o}, 32'd0);
        tick();
        check("force_trig_single", {31'd0, load_o},       32'd0);
        check("force_trig_level2", {29'd0, fifo_level_o}, 32'd1);

        // Reset during LOAD discards buffered entries
        push_val(4'h1);
        push_val(4'h2);
        check("rl_level3", {29'd0, fifo_level_o}, 32'd3);
        count_i = 4'hE;
        tick();
        check_load("rl_load");
        reset   = 1'b1;
        count_i = 4'h0;
        tick();
        reset = 1'b0;
        sb.delete();
        check("rl_load0",  {31'd0, load_o},           32'd0);
        check("rl_level0", {29'd0, fifo_level_o},     32'd0);
        check("rl_ready",  {31'd0, req_if.req_ready}, 32'd1);
        tick();
        count_i = 4'hE;
        tick();
        check("rl_no_stale", {31'd0, load_o},     32'd0);
        check("rl_ur",       {31'd0, underrun_o}, 32'd1);
        count_i = 4'h0;
        push_val(4'hD);
        count_i = 4'hE;
        tick();
        check_load("rl_fresh");
        count_i = 4'h0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule : tb_load_sequencer

// File: doc/load_sequencer.md
Name: load_sequencer

Overview:
- Upstream feeder for the 4-bit loadable up-counter.
- Accepts reload values over a valid/ready interface and buffers them in a small FIFO.
- Issues a one-cycle load pulse plus load value to the counter, timed so the new value replaces the counter's natural wrap.
- Also supports an immediate forced load and flags underruns (wrap needed, no value buffered).

Parameters:
- WIDTH, 4: counter/data width in bits.
- DEPTH, 4: FIFO entries; power of two, >= 2.
- TERM_VAL, all-ones of WIDTH: counter terminal value at which the counter wraps.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high; flushes FIFO and returns FSM to IDLE
- req_valid  in  1  reload value offered
- req_data  in  WIDTH  reload value
- req_ready  out  1  FIFO can accept; equals not-full, driven from registered state only
- force_i  in  1  request load of FIFO head at next edge, regardless of count
- count_i  in  WIDTH  current counter value (counter's registered output)
- clr_i  in  1  clears underrun_o
- load_o  out  1  registered one-cycle load pulse to counter
- load_val_o  out  WIDTH  registered load value; valid when load_o=1, holds last value otherwise
- fifo_level_o  out  clog2(DEPTH)+1  entries currently stored
- underrun_o  out  1  sticky underrun flag

Behaviour:
- Reset values: load_o=0, load_val_o=0, fifo_level_o=0, underrun_o=0, req_ready=1, FSM=IDLE, pointers=0.
- Push: when req_valid and req_ready are both high at an edge.
  - The entry is visible (level incremented) the next cycle; it cannot be popped in the cycle it is pushed.
  - When full, req_ready=0 even if a pop occurs in the same cycle.
  - Push and pop in the same cycle (not full): level unchanged, data order preserved.
- Trigger: count_i == TERM_VAL-1 (pre-terminal, modulo 2^WIDTH). A trigger or force_i in ARMED gives load_o=1 at the next edge, so load_o is high in the cycle count_i==TERM_VAL, overriding the counter's wrap.
- FSM states:
  - IDLE: FIFO empty. Trigger or force_i sets underrun_o (no load). On level becoming nonzero -> ARMED.
  - ARMED: FIFO nonempty. On trigger or force_i: pop head into load_val_o, load_o=1 next cycle -> LOAD.
  - LOAD: load_o=1 for exactly one cycle -> HOLD.
  - HOLD: one-cycle blackout; trigger and force_i are ignored, with no underrun. Exits to ARMED if level>0, else IDLE. This prevents a double load when the loaded value equals TERM_VAL-1.
- Trigger and force_i in the same cycle: one load, one pop.
- Underrun: sticky until clr_i. If clr_i and a new underrun occur in the same cycle, the set wins.
- Load latency: 1 cycle from the trigger/force cycle to load_o.
- No back-to-back loads: minimum spacing is 3 cycles (LOAD, HOLD, ARMED).
- Reset mid-operation (including during LOAD): load_o=0 at the next cycle and all buffered entries are discarded.
- Pointer arithmetic wraps modulo DEPTH. fifo_level_o never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: LOAD_SEQUENCER_UNDERRUN_CNT_EN.
- Defined: adds output underrun_cnt_o (8 bits).
  - Increments on each underrun event and saturates at 255.
  - Cleared by clr_i, with increment winning over clear in the same cycle, giving a value of 1.
  - Resets to 0.
- Undefined: port and counter absent; only the sticky underrun_o exists.

Test Plan:
- Reset, then push 4'h3 and 4'h9; drive count_i 4'hD then 4'hE. Expect load_o=1 with load_val_o=4'h3 in the 4'hE-following cycle and fifo_level_o dropping 2->1.
- Push 4 values with DEPTH=4. Expect req_ready=0 and level=4; a 5th req_valid is not accepted. After one trigger-driven pop, req_ready=1 the following cycle.
- FIFO empty, count_i=4'hE. Expect no load_o and underrun_o=1 held until clr_i pulse. With the macro enabled, underrun_cnt_o=1 and saturates at 255 after 300 underruns.
- Push 4'hE, 4'h5; trigger. Loaded 4'hE appears on count_i during HOLD and does not cause a second load. The next trigger loads 4'h5.
- force_i with level=1 and count_i=4'h2. Expect load_o=1 next cycle and level=0. force_i asserted together with a trigger produces a single load.
- Push 3 entries, assert reset during LOAD. Expect load_o=0, level=0, req_ready=1 on the next cycle and no stale values after release.
